// File: rtl/pll_lock_sequencer.sv
// PLL power-up sequencer: holds the PLL in reset, waits for a stable lock,
// then releases the core reset; retries on timeout or lock loss.
module pll_lock_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 74250,
    parameter int STABLE_CYCLES = 1024,
    parameter int CNT_W         = 17
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       core_reset,
    output logic       ready,
    output logic [1:0] state,
    output logic [7:0] lock_loss_cnt,
    output logic [7:0] timeout_cnt
);

    typedef enum logic [1:0] {
        RESET_HOLD = 2'd0,
        WAIT_LOCK  = 2'd1,
        STABLE     = 2'd2,
        RUN        = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             sync_q;
    logic             locked_s;
    logic             loss_inc;
    logic             timeout_inc;

    // The counter restarts from zero whenever the phase changes, so each
    // phase measures its own dwell time.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        loss_inc    = 1'b0;
        timeout_inc = 1'b0;
        if (relock_req) begin
            state_d = RESET_HOLD;
            cnt_d   = '0;
        end else begin
            case (state_q)
                RESET_HOLD: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_d     = RESET_HOLD;
                        cnt_d       = '0;
                        timeout_inc = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                STABLE: begin
                    if (!locked_s) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        state_d  = RESET_HOLD;
                        cnt_d    = '0;
                        loss_inc = 1'b1;
                    end
                end
                default: begin
                    state_d = RESET_HOLD;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as the state register.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q       <= RESET_HOLD;
            cnt_q         <= '0;
            sync_q        <= 1'b0;
            locked_s      <= 1'b0;
            pll_rst       <= 1'b1;
            core_reset    <= 1'b1;
            ready         <= 1'b0;
            lock_loss_cnt <= 8'd0;
            timeout_cnt   <= 8'd0;
        end else begin
            sync_q     <= pll_locked;
            locked_s   <= sync_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pll_rst    <= (state_d == RESET_HOLD);
            core_reset <= (state_d != RUN);
            ready      <= (state_d == RUN);
            if (loss_inc && (lock_loss_cnt != 8'hFF)) begin
                lock_loss_cnt <= lock_loss_cnt + 8'd1;
            end
            if (timeout_inc && (timeout_cnt != 8'hFF)) begin
                timeout_cnt <= timeout_cnt + 8'd1;
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: vector table, corner-case
// sequences and randomized traffic against a countdown-based reference model.
module tb_pll_lock_sequencer;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int STABLE_CYCLES = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst;
    logic       core_reset;
    logic       ready;
    logic [1:0] state;
    logic [7:0] lock_loss_cnt;
    logic [7:0] timeout_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    pll_lock_sequencer #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .CNT_W        (17)
    ) dut (
        .refclk       (clk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .relock_req   (relock_req),
        .pll_rst      (pll_rst),
        .core_reset   (core_reset),
        .ready        (ready),
        .state        (state),
        .lock_loss_cnt(lock_loss_cnt),
        .timeout_cnt  (timeout_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Phases: 0 hold, 1 wait, 2 stable, 3 run. m_left counts cycles still
    // allowed in the current phase; lk_q is the two-cycle lock delay line.
    int m_state;
    int m_left;
    int m_ll;
    int m_to;
    bit lk_q[$];

    function automatic void model_step(input logic r, input logic lk, input logic rq);
        bit ls;
        if (r) begin
            m_state = 0; m_left = RST_CYCLES; m_ll = 0; m_to = 0;
            lk_q.delete(); lk_q.push_back(1'b0); lk_q.push_back(1'b0);
            return;
        end
        ls = lk_q.pop_front();
        lk_q.push_back(lk);
        if (rq) begin
            m_state = 0; m_left = RST_CYCLES;
            return;
        end
        case (m_state)
            0: if (m_left == 1) begin m_state = 1; m_left = LOCK_TIMEOUT; end
               else m_left--;
            1: if (ls) begin m_state = 2; m_left = STABLE_CYCLES; end
               else if (m_left == 1) begin
                   m_state = 0; m_left = RST_CYCLES;
                   m_to = (m_to < 255) ? m_to + 1 : 255;
               end else m_left--;
            2: if (!ls) begin m_state = 1; m_left = LOCK_TIMEOUT; end
               else if (m_left == 1) m_state = 3;
               else m_left--;
            default: if (!ls) begin
                   m_state = 0; m_left = RST_CYCLES;
                   m_ll = (m_ll < 255) ? m_ll + 1 : 255;
               end
        endcase
    endfunction

    // ---------------- checking ----------------
    function automatic void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endfunction

    function automatic void check_model();
        chk("model_state", int'(state), m_state);
        chk("model_pll_rst", int'(pll_rst), (m_state == 0) ? 1 : 0);
        chk("model_core_reset", int'(core_reset), (m_state != 3) ? 1 : 0);
        chk("model_ready", int'(ready), (m_state == 3) ? 1 : 0);
        chk("model_lock_loss_cnt", int'(lock_loss_cnt), m_ll);
        chk("model_timeout_cnt", int'(timeout_cnt), m_to);
    endfunction

    // Drive one cycle of inputs, advance the model, sample #1 after the edge.
    task automatic step(input logic r, input logic lk, input logic rq);
        rst = r; pll_locked = lk; relock_req = rq;
        model_step(r, lk, rq);
        @(posedge clk);
        #1;
        check_model();
        rst = 1'b0; relock_req = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       r;
        logic       lk;
        logic       rq;
        logic [1:0] st;
        logic [7:0] ll;
        logic [7:0] to;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input int n, input logic r, input logic lk, input logic rq,
                                input logic [1:0] st, input logic [7:0] ll);
        vec_t v;
        v.r = r; v.lk = lk; v.rq = rq; v.st = st; v.ll = ll; v.to = 8'd0;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endfunction

    initial begin : main
        int cnt;
        int k;
        bit  saw_fallback;
        bit  core_ok;
        logic lk_r;
        logic [1:0] prev_st;

        // Power-up, clean lock, lock loss in RUN and re-lock.
        add(3, 1, 0, 0, 2'd0, 8'd0);
        add(3, 0, 0, 0, 2'd0, 8'd0);
        add(7, 0, 0, 0, 2'd1, 8'd0);
        add(2, 0, 1, 0, 2'd1, 8'd0);
        add(8, 0, 1, 0, 2'd2, 8'd0);
        add(4, 0, 1, 0, 2'd3, 8'd0);
        add(2, 0, 0, 0, 2'd3, 8'd0);
        add(1, 0, 0, 0, 2'd0, 8'd1);
        add(3, 0, 1, 0, 2'd0, 8'd1);
        add(1, 0, 1, 0, 2'd1, 8'd1);
        add(8, 0, 1, 0, 2'd2, 8'd1);
        add(2, 0, 1, 0, 2'd3, 8'd1);

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].lk, tbl[i].rq);
            chk($sformatf("tbl%0d_state", i), int'(state), int'(tbl[i].st));
            chk($sformatf("tbl%0d_pll_rst", i), int'(pll_rst), (tbl[i].st == 2'd0) ? 1 : 0);
            chk($sformatf("tbl%0d_core_reset", i), int'(core_reset), (tbl[i].st != 2'd3) ? 1 : 0);
            chk($sformatf("tbl%0d_ready", i), int'(ready), (tbl[i].st == 2'd3) ? 1 : 0);
            chk($sformatf("tbl%0d_lock_loss", i), int'(lock_loss_cnt), int'(tbl[i].ll));
            chk($sformatf("tbl%0d_timeout", i), int'(timeout_cnt), int'(tbl[i].to));
        end

        // relock_req in RUN, then again in the second cycle of RESET_HOLD.
        step(0, 1, 1);
        chk("relock1_state", int'(state), 0);
        step(0, 1, 0);
        step(0, 1, 1);
        chk("relock2_state", int'(state), 0);
        cnt = 1;
        k = 0;
        while (pll_rst && k < 20) begin
            step(0, 1, 0);
            if (pll_rst) cnt++;
            k++;
        end
        chk("relock_hold_len", cnt, RST_CYCLES);
        chk("relock_loss_cnt", int'(lock_loss_cnt), 1);
        chk("relock_timeout_cnt", int'(timeout_cnt), 0);

        // Unstable lock: high 5, low 1, then high.
        step(1, 0, 0);
        step(1, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0);
        saw_fallback = 0;
        prev_st = state;
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0);
            prev_st = state;
        end
        step(0, 0, 0);
        if (prev_st == 2'd2 && state == 2'd1) saw_fallback = 1;
        prev_st = state;
        step(0, 1, 0);
        if (prev_st == 2'd2 && state == 2'd1) saw_fallback = 1;
        k = 0;
        while (state != 2'd3 && k < 40) begin
            prev_st = state;
            step(0, 1, 0);
            if (prev_st == 2'd2 && state == 2'd1) saw_fallback = 1;
            k++;
        end
        chk("unstable_fallback_seen", int'(saw_fallback), 1);
        chk("unstable_run_latency", k, STABLE_CYCLES + 2);
        chk("unstable_timeout_cnt", int'(timeout_cnt), 0);

        // Timeout retry and saturation.
        step(1, 0, 0);
        core_ok = 1;
        for (int i = 0; i < 2 * (RST_CYCLES + LOCK_TIMEOUT); i++) begin
            step(0, 0, 0);
            if (!core_reset) core_ok = 0;
        end
        chk("timeout_two_retries", int'(timeout_cnt), 2);
        chk("timeout_in_hold", int'(state), 0);
        for (int i = 0; i < 300 * (RST_CYCLES + LOCK_TIMEOUT); i++) begin
            step(0, 0, 0);
            if (!core_reset) core_ok = 0;
        end
        chk("timeout_core_held", int'(core_ok), 1);
        chk("timeout_saturated", int'(timeout_cnt), 255);
        for (int i = 0; i < 50; i++) step(0, 0, 0);
        chk("timeout_sat_hold", int'(timeout_cnt), 255);
        step(1, 0, 0);
        chk("timeout_rst_clear", int'(timeout_cnt), 0);

        // Randomized traffic against the model.
        lk_r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) lk_r = ~lk_r;
            step(($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0, lk_r,
                 ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Sequences the clock-generation PLL (74.25 MHz reference, five derived game clocks) from power-up to a usable state.
- Drives the PLL reset and monitors its lock output. Releases the core reset only after lock has been stable for a programmable time.
- On lock loss or timeout, re-arms the PLL automatically and keeps saturating event counters for debug.
- Runs entirely in the reference clock domain and sits between the PLL wrapper and the core reset tree.

Parameters:
- RST_CYCLES, 16: cycles pll_rst is held high on each entry to RESET_HOLD (≥1).
- LOCK_TIMEOUT, 74250: cycles allowed in WAIT_LOCK before retry (1 ms at 74.25 MHz; ≥2).
- STABLE_CYCLES, 1024: consecutive synced-lock cycles required before RUN (≥1).
- CNT_W, 17: width of the shared phase counter. Must hold max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).

Ports:
- refclk  in  1  sole clock. The PLL reference clock, 74.25 MHz.
- rst  in  1  synchronous, active-high reset.
- pll_locked  in  1  PLL lock output, asynchronous to refclk.
- relock_req  in  1  single-cycle request to force a full PLL re-lock.
- pll_rst  out  1  reset to the PLL, active-high.
- core_reset  out  1  reset to the game core, active-high.
- ready  out  1  high only in RUN; equals ~core_reset.
- state  out  2  encoding: 0 RESET_HOLD, 1 WAIT_LOCK, 2 STABLE, 3 RUN.
- lock_loss_cnt  out  8  count of RUN→RESET_HOLD transitions caused by lock loss; saturates at 255.
- timeout_cnt  out  8  count of WAIT_LOCK timeouts; saturates at 255.

Behaviour:
- Clock and reset: one clock (refclk). Reset rst is synchronous and active-high.
- Reset values: state=RESET_HOLD, phase counter=0, pll_rst=1, core_reset=1, ready=0, lock_loss_cnt=0, timeout_cnt=0, sync flops=0.
- Synchronizer: pll_locked passes through a 2-flop synchronizer to give locked_s (2-cycle latency). The FSM uses only locked_s.
- All outputs are registered. pll_rst=1 iff state is RESET_HOLD. core_reset=0 iff state is RUN.
- Phase counter: clears to 0 on every state change and on every STABLE→WAIT_LOCK fall-back.
- RESET_HOLD:
  - Counter increments each cycle.
  - When counter==RST_CYCLES-1, go to WAIT_LOCK. pll_rst is therefore high for exactly RST_CYCLES cycles.
- WAIT_LOCK:
  - If locked_s=1, go to STABLE.
  - Otherwise, if counter==LOCK_TIMEOUT-1, go to RESET_HOLD and increment timeout_cnt (saturating).
  - Otherwise, increment the counter.
- STABLE:
  - If locked_s=0, go to WAIT_LOCK with the timeout window restarted. No counter increment.
  - Otherwise, if counter==STABLE_CYCLES-1, go to RUN.
  - Otherwise, increment the counter.
- RUN:
  - If locked_s=0, go to RESET_HOLD and increment lock_loss_cnt (saturating).
  - core_reset and pll_rst rise on the same edge that enters RESET_HOLD, i.e. 3 cycles after pll_locked falls.
- relock_req, sampled in any state:
  - Sends the FSM to RESET_HOLD with the counter cleared.
  - In RESET_HOLD it restarts the hold count.
  - It does not increment either event counter.
- Priority: rst > relock_req > lock loss / timeout > normal counting.
- Glitches: a lock glitch shorter than one refclk cycle may or may not be seen. Once seen, it is always acted on; there is no filtering beyond the synchronizer.
- Saturation: event counters hold at 255 and never wrap. They are cleared only by rst.
- Reset mid-operation: rst in any state returns all outputs to their reset values on the next edge. The PLL is therefore re-reset.

Test Plan:
Benches use RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8.
- Power-up, clean lock:
  - Stimulus: rst for 3 cycles; pll_locked rises 10 cycles after rst falls and stays high.
  - Required: pll_rst high for exactly 4 cycles after rst; state goes 0→1→2→3; core_reset falls exactly 2+8 cycles after pll_locked rises (+1 WAIT_LOCK exit); ready=1; both counters=0.
- Timeout retry:
  - Stimulus: pll_locked held low.
  - Required: cycle of 4 pll_rst cycles then 20 WAIT_LOCK cycles, repeated; timeout_cnt increments each cycle; core_reset stays 1.
- Unstable lock:
  - Stimulus: pll_locked high for 5 cycles, low 1 cycle, then high.
  - Required: STABLE→WAIT_LOCK→STABLE; RUN is reached only 8 locked_s cycles after the last rising edge; timeout_cnt=0.
- Lock loss in RUN:
  - Stimulus: drop pll_locked.
  - Required: core_reset=1 and pll_rst=1 three cycles later; lock_loss_cnt=1; normal re-lock follows.
- relock_req:
  - Stimulus: pulse relock_req in RUN, and again in cycle 2 of RESET_HOLD.
  - Required: immediate RESET_HOLD; the hold restarts and pll_rst stays high 4 cycles after the second pulse; no counter changes.
- Saturation:
  - Stimulus: force 300 timeouts.
  - Required: timeout_cnt reads 255 and holds; rst clears it to 0.
